// File: rtl/sipo_deser.sv
// Parametrised serial-in/parallel-out deserialiser with a valid/ready output register.
// Optional even-parity framing is enabled by defining SIPO_DESER_PARITY_EN.
module sipo_deser #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          LSB_FIRST = 1'b0
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         clear,
    input  logic                         shift_en,
    input  logic                         serial_in,
    output logic [WIDTH-1:0]             live_data,
    output logic [$clog2(WIDTH+1)-1:0]   bit_cnt,
    output logic [WIDTH-1:0]             out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         overrun
`ifdef SIPO_DESER_PARITY_EN
    ,
    output logic                         out_perr
`endif
);

    localparam int unsigned CW = $clog2(WIDTH+1);
`ifdef SIPO_DESER_PARITY_EN
    localparam int unsigned LAST_IDX = WIDTH;
`else
    localparam int unsigned LAST_IDX = WIDTH - 1;
`endif
    localparam logic [CW-1:0] LAST_CNT = CW'(LAST_IDX);

    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic             perr_q, perr_d;

    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] done_word;
    logic             done_perr;
    logic             last_bit;
    logic             complete;
    logic             xfer;
    logic             shift_sr;

    always_comb begin
        shifted   = '0;
        done_word = '0;
        done_perr = 1'b0;
        shift_sr  = 1'b0;

        if (LSB_FIRST) begin
            shifted = {serial_in, sr_q[WIDTH-1:1]};
        end else begin
            shifted = {sr_q[WIDTH-2:0], serial_in};
        end

        last_bit = (cnt_q == LAST_CNT);
        complete = shift_en && last_bit;
        xfer     = valid_q && out_ready;

`ifdef SIPO_DESER_PARITY_EN
        // The parity bit never enters the shift stage; the word is already complete in sr.
        shift_sr  = shift_en && !last_bit;
        done_word = sr_q;
        done_perr = (^sr_q) ^ serial_in;
`else
        shift_sr  = shift_en;
        done_word = shifted;
        done_perr = 1'b0;
`endif
    end

    always_comb begin
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        perr_d  = perr_q;

        if (clear) begin
            sr_d    = '0;
            cnt_d   = '0;
            data_d  = '0;
            valid_d = 1'b0;
            ovr_d   = 1'b0;
            perr_d  = 1'b0;
        end else begin
            if (shift_sr) begin
                sr_d = shifted;
            end
            if (shift_en) begin
                cnt_d = last_bit ? '0 : cnt_q + CW'(1);
            end
            if (xfer) begin
                valid_d = 1'b0;
            end
            // A transfer on the completing edge frees the register for the new word.
            if (complete) begin
                if (!valid_q || xfer) begin
                    data_d  = done_word;
                    perr_d  = done_perr;
                    valid_d = 1'b1;
                end else begin
                    ovr_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr_q    <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            perr_q  <= perr_d;
        end
    end

    assign live_data = sr_q;
    assign bit_cnt   = cnt_q;
    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign overrun   = ovr_q;
`ifdef SIPO_DESER_PARITY_EN
    assign out_perr  = perr_q;
`else
    logic unused_perr;
    assign unused_perr = perr_q ^ done_perr;
`endif

endmodule

// File: tb/tb_sipo_deser.sv
// Scoreboard bench for sipo_deser: one MSB-first and one LSB-first instance share stimulus.
// Honours SIPO_DESER_PARITY_EN by appending a parity bit to every frame.
module tb_sipo_deser;

    localparam int unsigned W  = 8;
    localparam int unsigned CW = $clog2(W+1);

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic clear = 1'b0;
    logic shift_en = 1'b0;
    logic serial_in = 1'b0;
    logic out_ready = 1'b1;

    logic [W-1:0]  live0, data0, live1, data1;
    logic [CW-1:0] cnt0, cnt1;
    logic          valid0, ovr0, valid1, ovr1;
`ifdef SIPO_DESER_PARITY_EN
    logic          perr0, perr1;
`endif

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];

    always #5 clk = ~clk;

    sipo_deser #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_msb (
        .clk(clk), .reset_n(reset_n), .clear(clear), .shift_en(shift_en),
        .serial_in(serial_in), .live_data(live0), .bit_cnt(cnt0),
        .out_data(data0), .out_valid(valid0), .out_ready(out_ready),
        .overrun(ovr0)
`ifdef SIPO_DESER_PARITY_EN
        , .out_perr(perr0)
`endif
    );

    sipo_deser #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_lsb (
        .clk(clk), .reset_n(reset_n), .clear(clear), .shift_en(shift_en),
        .serial_in(serial_in), .live_data(live1), .bit_cnt(cnt1),
        .out_data(data1), .out_valid(valid1), .out_ready(out_ready),
        .overrun(ovr1)
`ifdef SIPO_DESER_PARITY_EN
        , .out_perr(perr1)
`endif
    );

    function automatic logic [W-1:0] rev(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < int'(W); i++) r[i] = v[int'(W)-1-i];
        return r;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic shift_bit(input logic b);
        shift_en  = 1'b1;
        serial_in = b;
        @(posedge clk);
        #1;
        shift_en  = 1'b0;
        serial_in = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Sends w MSB first; rdy_last raises out_ready only for the completing edge.
    task automatic send_word(input logic [W-1:0] w, input bit rdy_last, input int gap_after,
                             input bit bad_par);
        for (int i = int'(W) - 1; i >= 0; i--) begin
            if (gap_after != 0 && (int'(W) - 1 - i) == gap_after) begin
                repeat (5) begin
                    @(posedge clk);
                    #1;
                    check_eq("gap_cnt", 32'(cnt0), 32'(gap_after));
                end
            end
`ifndef SIPO_DESER_PARITY_EN
            if (i == 0 && rdy_last) out_ready = 1'b1;
`endif
            shift_bit(w[i]);
        end
`ifdef SIPO_DESER_PARITY_EN
        if (rdy_last) out_ready = 1'b1;
        shift_bit((^w) ^ bad_par);
`else
        if (bad_par) shift_en = 1'b0;
`endif
        if (rdy_last) out_ready = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_live"}, 32'(live0), 32'd0);
        check_eq({tag, "_cnt"}, 32'(cnt0), 32'd0);
        check_eq({tag, "_data"}, 32'(data0), 32'd0);
        check_eq({tag, "_valid"}, 32'(valid0), 32'd0);
        check_eq({tag, "_ovr"}, 32'(ovr0), 32'd0);
        check_eq({tag, "_valid_lsb"}, 32'(valid1), 32'd0);
    endtask

    // Transfer happens on the next rising edge whenever valid and ready are both high.
    always @(negedge clk) begin
        if (reset_n && !clear && out_ready) begin
            if (valid0) begin
                if (q0.size() == 0) check_eq("sb_msb_underflow", 32'(q0.size()), 32'd1);
                else check_eq("sb_msb_word", 32'(data0), 32'(q0.pop_front()));
            end
            if (valid1) begin
                if (q1.size() == 0) check_eq("sb_lsb_underflow", 32'(q1.size()), 32'd1);
                else check_eq("sb_lsb_word", 32'(data1), 32'(q1.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #12;
        check_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;
        idle(1);

        // 0xA5 with consumer ready: zero-latency delivery, valid drops next cycle
        out_ready = 1'b1;
        q0.push_back(8'hA5);
        q1.push_back(rev(8'hA5));
        send_word(8'hA5, 1'b0, 0, 1'b0);
        check_eq("a5_valid", 32'(valid0), 32'd1);
        check_eq("a5_data", 32'(data0), 32'hA5);
        check_eq("a5_data_lsb", 32'(data1), 32'hA5);
        check_eq("a5_cnt", 32'(cnt0), 32'd0);
        idle(1);
        check_eq("a5_valid_drop", 32'(valid0), 32'd0);

        // bit order: 1,1,0,0,0,0,0,0
        q0.push_back(8'hC0);
        q1.push_back(8'h03);
        send_word(8'hC0, 1'b0, 0, 1'b0);
        check_eq("order_msb", 32'(data0), 32'hC0);
        check_eq("order_lsb", 32'(data1), 32'h03);
        idle(1);

        // overrun: second word dropped, flag sticky until clear
        out_ready = 1'b0;
        q0.push_back(8'h3C);
        q1.push_back(rev(8'h3C));
        send_word(8'h3C, 1'b0, 0, 1'b0);
        check_eq("ovr_first_flag", 32'(ovr0), 32'd0);
        send_word(8'hF0, 1'b0, 0, 1'b0);
        check_eq("ovr_data", 32'(data0), 32'h3C);
        check_eq("ovr_data_lsb", 32'(data1), 32'h3C);
        check_eq("ovr_flag", 32'(ovr0), 32'd1);
        check_eq("ovr_flag_lsb", 32'(ovr1), 32'd1);
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;
        check_eq("ovr_drain_valid", 32'(valid0), 32'd0);
        check_eq("ovr_sticky", 32'(ovr0), 32'd1);
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
        check_eq("ovr_cleared", 32'(ovr0), 32'd0);

        // transfer and load on the same edge
        q0.push_back(8'h11);
        q1.push_back(rev(8'h11));
        send_word(8'h11, 1'b0, 0, 1'b0);
        q0.push_back(8'h22);
        q1.push_back(rev(8'h22));
        send_word(8'h22, 1'b1, 0, 1'b0);
        check_eq("same_edge_valid", 32'(valid0), 32'd1);
        check_eq("same_edge_data", 32'(data0), 32'h22);
        check_eq("same_edge_data_lsb", 32'(data1), 32'h44);
        check_eq("same_edge_ovr", 32'(ovr0), 32'd0);
        out_ready = 1'b1;
        idle(1);
        check_eq("same_edge_drain", 32'(valid0), 32'd0);

        // shift_en gap of 5 cycles after 4 bits
        q0.push_back(8'h96);
        q1.push_back(rev(8'h96));
        send_word(8'h96, 1'b0, 4, 1'b0);
        check_eq("gap_data", 32'(data0), 32'h96);
        idle(1);

        // async reset mid-frame
        out_ready = 1'b0;
        send_word(8'h5A, 1'b0, 0, 1'b0);
        shift_bit(1'b1); shift_bit(1'b0); shift_bit(1'b1); shift_bit(1'b1); shift_bit(1'b0);
        check_eq("mid_cnt", 32'(cnt0), 32'd5);
        check_eq("mid_valid", 32'(valid0), 32'd1);
        check_eq("mid_live_msb", 32'(live0), 32'h56);
        check_eq("mid_live_lsb", 32'(live1), 32'h6A);
        #2;
        reset_n = 1'b0;
        #1;
        check_zero("async_rst");
        #1;
        reset_n = 1'b1;
        idle(1);

        // synchronous clear mid-frame
        send_word(8'h5A, 1'b0, 0, 1'b0);
        shift_bit(1'b1); shift_bit(1'b0); shift_bit(1'b1); shift_bit(1'b1); shift_bit(1'b0);
        clear = 1'b1;
        #2;
        check_eq("clear_is_sync", 32'(valid0), 32'd1);
        @(posedge clk);
        #1;
        clear = 1'b0;
        check_zero("sync_clr");

`ifdef SIPO_DESER_PARITY_EN
        out_ready = 1'b1;
        q0.push_back(8'hA5);
        q1.push_back(rev(8'hA5));
        send_word(8'hA5, 1'b0, 0, 1'b0);
        check_eq("par_good_perr", 32'(perr0), 32'd0);
        check_eq("par_good_data", 32'(data0), 32'hA5);
        q0.push_back(8'hA5);
        q1.push_back(rev(8'hA5));
        send_word(8'hA5, 1'b0, 0, 1'b1);
        check_eq("par_bad_perr", 32'(perr0), 32'd1);
        check_eq("par_bad_perr_lsb", 32'(perr1), 32'd1);
        check_eq("par_bad_data", 32'(data0), 32'hA5);
`endif

        out_ready = 1'b1;
        idle(3);
        check_eq("sb_msb_drained", 32'(q0.size()), 32'd0);
        check_eq("sb_lsb_drained", 32'(q1.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
